// File: rtl/controle_preco.sv
// controle_preco - sequencing controller for the preco multiplier of the scale.
//
// Waits for the load-cell sample stream to settle and takes the price per kg from the
// price register. It then drives the two preco operands and captures total_price
// MUL_LAT cycles later. The result is presented on a valid/ready handshake.
//
// Optional feature: define TARE_EN to enable tare capture. With TARE_EN, tare_req in IDLE
// while stable stores the current weight as tare, and the net weight is gross minus tare,
// saturating at zero. Without it, tare_req is ignored and the net weight equals the gross weight.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   sample_valid/sample_weight  load-cell sample stream (gross weight)
//   price_valid/price_in        price per kg load
//   tare_req                    tare capture request (TARE_EN only)
//   start                       single-cycle request for one pricing transaction
//   weight_kg/price_per_kg      operands to preco, held between transactions
//   total_price                 product from preco
//   result_valid/result_ready   result handshake
//   result_price/result_weight  captured price and net weight
//   stable, busy                status
//   err_no_price, err_timeout   single-cycle error pulses
`timescale 1ns/1ps

module controle_preco #(
    parameter int W          = 16,
    parameter int STABLE_CNT = 4,
    parameter int TOL        = 2,
    parameter int MUL_LAT    = 1,
    parameter int TIMEOUT    = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_valid,
    input  logic [W-1:0] sample_weight,
    input  logic         price_valid,
    input  logic [W-1:0] price_in,
    input  logic         tare_req,
    input  logic         start,
    output logic [W-1:0] weight_kg,
    output logic [W-1:0] price_per_kg,
    input  logic [W-1:0] total_price,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [W-1:0] result_price,
    output logic [W-1:0] result_weight,
    output logic         stable,
    output logic         busy,
    output logic         err_no_price,
    output logic         err_timeout
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] STAB_MAX   = CW'(STABLE_CNT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] WAIT_LAST  = LW'(MUL_LAT - 1);
    localparam logic [W-1:0]  TOL_W      = W'(TOL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  prev_sample;
    logic [W-1:0]  diff;
    logic [CW-1:0] stab_cnt;
    logic [CW-1:0] stab_cnt_next;
    logic [W-1:0]  price_reg;
    logic          price_loaded;
    logic [TW-1:0] settle_timer;
    logic [LW-1:0] wait_cnt;
    logic [W-1:0]  net_weight;

    // Absolute step between consecutive samples and the next stability count.
    always_comb begin
        diff          = (sample_weight >= prev_sample) ? (sample_weight - prev_sample)
                                                       : (prev_sample - sample_weight);
        stab_cnt_next = stab_cnt;
        if (sample_valid) begin
            if (diff <= TOL_W) begin
                stab_cnt_next = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 1'b1;
            end else begin
                stab_cnt_next = '0;
            end
        end
    end

    // stable is registered from the next count so it lines up with the counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= '0;
            stab_cnt    <= '0;
            stable      <= 1'b0;
        end else begin
            if (sample_valid) begin
                prev_sample <= sample_weight;
            end
            stab_cnt <= stab_cnt_next;
            stable   <= (stab_cnt_next == STAB_MAX);
        end
    end

    // A price load in any state affects only the next LOAD; the operands are held separately.
    always_ff @(posedge clk) begin
        if (rst) begin
            price_reg    <= '0;
            price_loaded <= 1'b0;
        end else if (price_valid) begin
            price_reg    <= price_in;
            price_loaded <= 1'b1;
        end
    end

`ifdef TARE_EN
    logic [W-1:0] tare;

    always_ff @(posedge clk) begin
        if (rst) begin
            tare <= '0;
        end else if (state == S_IDLE && stable && tare_req) begin
            tare <= prev_sample;
        end
    end

    // A tare larger than the gross weight clamps to zero rather than wrapping.
    assign net_weight = (prev_sample >= tare) ? (prev_sample - tare) : '0;
`else
    logic unused_tare_req;

    assign unused_tare_req = tare_req;
    assign net_weight      = prev_sample;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            err_no_price  <= 1'b0;
            err_timeout   <= 1'b0;
            result_valid  <= 1'b0;
            result_price  <= '0;
            result_weight <= '0;
            weight_kg     <= '0;
            price_per_kg  <= '0;
            settle_timer  <= '0;
            wait_cnt      <= '0;
        end else begin
            err_no_price <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!price_loaded) begin
                            err_no_price <= 1'b1;
                        end else begin
                            state        <= S_SETTLE;
                            busy         <= 1'b1;
                            settle_timer <= '0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (stable) begin
                        state <= S_LOAD;
                    end else if (settle_timer == TIMER_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        settle_timer <= settle_timer + 1'b1;
                    end
                end
                S_LOAD: begin
                    weight_kg    <= net_weight;
                    price_per_kg <= price_reg;
                    wait_cnt     <= '0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    // weight_kg still holds the net weight that produced total_price.
                    if (wait_cnt == WAIT_LAST) begin
                        result_price  <= total_price;
                        result_weight <= weight_kg;
                        result_valid  <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
